// File: rtl/rv32ima_pkg.sv
// rv32ima_pkg: shared core types, load/store width codes and RAM arbiter enums.
package rv32ima_pkg;
    typedef logic [31:0] word_t;
    localparam int LDST_WIDTH_W = 2;
    localparam logic [LDST_WIDTH_W-1:0] LDST_BYTE = 2'd0;
    localparam logic [LDST_WIDTH_W-1:0] LDST_HALF = 2'd1;
    localparam logic [LDST_WIDTH_W-1:0] LDST_WORD = 2'd2;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
    typedef enum logic {SRC_IF, SRC_D} arb_src_t;
endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: picks the next RAM grantee; D wins unless IF has starved MAX_STARVE times.
module ram_arb_pick
    import rv32ima_pkg::*;
#(
    parameter int MAX_STARVE = 4,
    parameter int SW         = $clog2(MAX_STARVE + 1)
) (
    input  logic          i_if_req,
    input  logic          i_d_req,
    input  logic [SW-1:0] i_starve_cnt,
    output logic          o_grant_valid,
    output arb_src_t      o_grant_src
);
    logic w_if_forced;
    assign w_if_forced   = i_if_req && (i_starve_cnt == SW'(MAX_STARVE));
    assign o_grant_valid = i_if_req || i_d_req;
    assign o_grant_src   = (i_d_req && !w_if_forced) ? SRC_D : SRC_IF;
endmodule

// File: rtl/cpu_ram_arbiter.sv
// cpu_ram_arbiter: shares the single CPU<->RAM port between instruction fetch and data access,
// sequencing arbitrate -> access -> respond with D priority and bounded IF starvation.
module cpu_ram_arbiter
    import rv32ima_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic                    ram_clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  word_t                   if_addr,
    output logic                    if_ready,
    output word_t                   if_rdata,
    input  logic                    d_req,
    input  logic                    d_wen,
    input  word_t                   d_addr,
    input  word_t                   d_wdata,
    input  logic [LDST_WIDTH_W-1:0] d_width,
    output logic                    d_ready,
    output word_t                   d_rdata,
    output logic [31:0]             ram_addr,
    output logic [31:0]             ram_store,
    output logic                    ram_ren,
    output logic                    ram_wen,
    output logic [LDST_WIDTH_W-1:0] ram_width,
    input  logic [31:0]             ram_load
);
    localparam int LW = $clog2(RD_LAT + 1);
    localparam int SW = $clog2(MAX_STARVE + 1);

    arb_state_t              r_state;
    arb_src_t                r_src;
    logic                    r_store;
    logic [LW-1:0]           r_lat;
    logic [SW-1:0]           r_starve;
    logic                    r_if_ready;
    logic                    r_d_ready;
    word_t                   r_if_rdata;
    word_t                   r_d_rdata;
    word_t                   r_ram_addr;
    word_t                   r_ram_store;
    logic                    r_ram_ren;
    logic                    r_ram_wen;
    logic [LDST_WIDTH_W-1:0] r_ram_width;
    logic                    w_grant_valid;
    arb_src_t                w_grant_src;

    ram_arb_pick #(.MAX_STARVE(MAX_STARVE), .SW(SW)) u_pick (
        .i_if_req      (if_req),
        .i_d_req       (d_req),
        .i_starve_cnt  (r_starve),
        .o_grant_valid (w_grant_valid),
        .o_grant_src   (w_grant_src)
    );

    always_ff @(posedge ram_clk) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_src       <= SRC_IF;
            r_store     <= 1'b0;
            r_lat       <= '0;
            r_starve    <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_ram_addr  <= '0;
            r_ram_store <= '0;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_ram_width <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (!d_req) r_starve <= '0;
                    if (w_grant_valid) begin
                        r_state <= ARB_ACCESS;
                        r_src   <= w_grant_src;
                        r_lat   <= LW'(RD_LAT - 1);
                        if (w_grant_src == SRC_D) begin
                            r_store     <= d_wen;
                            r_ram_ren   <= !d_wen;
                            r_ram_wen   <= d_wen;
                            r_ram_addr  <= d_addr;
                            r_ram_store <= d_wen ? d_wdata : '0;
                            r_ram_width <= d_width;
                            if (if_req && r_starve != SW'(MAX_STARVE)) r_starve <= r_starve + SW'(1);
                        end else begin
                            r_store     <= 1'b0;
                            r_ram_ren   <= 1'b1;
                            r_ram_wen   <= 1'b0;
                            r_ram_addr  <= if_addr;
                            r_ram_store <= '0;
                            r_ram_width <= LDST_WORD;
                            r_starve    <= '0;
                        end
                    end
                end
                ARB_ACCESS: begin
                    // stores finish after one wen cycle; reads once the latency counter drains
                    if (r_store || r_lat == '0) begin
                        r_state     <= ARB_RESP;
                        r_ram_ren   <= 1'b0;
                        r_ram_wen   <= 1'b0;
                        r_ram_addr  <= '0;
                        r_ram_store <= '0;
                        r_ram_width <= '0;
                        if (r_src == SRC_IF) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= ram_load;
                        end else begin
                            r_d_ready <= 1'b1;
                            r_d_rdata <= r_store ? '0 : ram_load;
                        end
                    end else begin
                        r_lat <= r_lat - LW'(1);
                    end
                end
                ARB_RESP: begin
                    r_if_ready <= 1'b0;
                    r_d_ready  <= 1'b0;
                    r_state    <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign ram_addr  = r_ram_addr;
    assign ram_store = r_ram_store;
    assign ram_ren   = r_ram_ren;
    assign ram_wen   = r_ram_wen;
    assign ram_width = r_ram_width;
endmodule

// File: tb/tb_cpu_ram_arbiter.sv
// tb_cpu_ram_arbiter: directed and randomized checks of cpu_ram_arbiter against a
// transaction-timeline reference model and a behavioural RAM.
module tb_cpu_ram_arbiter;
    import rv32ima_pkg::*;
    localparam int RD_LAT = 1;
    localparam int MAX_STARVE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic if_req = 1'b0, if_ready;
    word_t if_addr = '0, if_rdata;
    logic d_req = 1'b0, d_wen = 1'b0, d_ready;
    word_t d_addr = '0, d_wdata = '0, d_rdata;
    logic [LDST_WIDTH_W-1:0] d_width = '0, ram_width;
    logic [31:0] ram_addr, ram_store, ram_load = '0;
    logic ram_ren, ram_wen;

    cpu_ram_arbiter #(.RD_LAT(RD_LAT), .MAX_STARVE(MAX_STARVE)) u_dut (
        .ram_clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_width(d_width),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_store(ram_store), .ram_ren(ram_ren), .ram_wen(ram_wen),
        .ram_width(ram_width), .ram_load(ram_load)
    );

    logic rst3 = 1'b1, d_req3 = 1'b0, if_ready3, d_ready3, ram_ren3, ram_wen3;
    word_t d_addr3 = '0, if_rdata3, d_rdata3;
    logic [31:0] ram_addr3, ram_store3, ram_load3 = 32'hFFFF_FFFF;
    logic [LDST_WIDTH_W-1:0] ram_width3;

    cpu_ram_arbiter #(.RD_LAT(3), .MAX_STARVE(MAX_STARVE)) u_dut3 (
        .ram_clk(clk), .rst(rst3),
        .if_req(1'b0), .if_addr(32'h0), .if_ready(if_ready3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_wen(1'b0), .d_addr(d_addr3), .d_wdata(32'h0), .d_width(LDST_WORD),
        .d_ready(d_ready3), .d_rdata(d_rdata3),
        .ram_addr(ram_addr3), .ram_store(ram_store3), .ram_ren(ram_ren3), .ram_wen(ram_wen3),
        .ram_width(ram_width3), .ram_load(ram_load3)
    );

    a_if_hold: assert property (@(posedge clk) disable iff (rst)
        (if_req && !if_ready) |=> (if_ready || (if_req && $stable(if_addr))))
        else $error("if request changed before if_ready");
    a_d_hold: assert property (@(posedge clk) disable iff (rst)
        (d_req && !d_ready) |=> (d_ready || (d_req && $stable({d_wen, d_addr, d_wdata, d_width}))))
        else $error("d request changed before d_ready");

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word_t dflt(input word_t a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    word_t ref_mem[word_t];
    word_t ram_mem[word_t];
    int k = 0, m_free = 0, m_g = 0, m_rdy = 0, starve = 0, ren_run = 0;
    bit m_act = 0, m_isd = 0, m_st = 0, e_ren, e_wen, e_if_rdy, e_d_rdy;
    word_t m_addr, m_wdata, m_rd, e_if_rdata = '0, e_d_rdata = '0;
    logic [LDST_WIDTH_W-1:0] m_w;

    // One clock: model decides what this edge does, then the DUT is compared and the RAM answers.
    task automatic step();
        bit gd, ctl;
        int idx;
        k++;
        if (rst) begin
            m_act = 0; m_free = k + 1; starve = 0; e_if_rdata = '0; e_d_rdata = '0;
        end else if (k >= m_free) begin
            if (!d_req) starve = 0;
            if (if_req || d_req) begin
                gd = d_req && !(if_req && starve == MAX_STARVE);
                if (!gd) starve = 0;
                else if (if_req && starve < MAX_STARVE) starve++;
                m_act = 1; m_isd = gd; m_st = gd && d_wen; m_g = k;
                m_addr = gd ? d_addr : if_addr;
                m_w = gd ? d_width : LDST_WORD;
                m_wdata = d_wdata;
                m_rd = m_st ? '0 : (ref_mem.exists(m_addr) ? ref_mem[m_addr] : dflt(m_addr));
                if (m_st) ref_mem[m_addr] = d_wdata;
                m_rdy = k + (m_st ? 1 : RD_LAT);
                m_free = m_rdy + 2;
            end
        end
        e_ren = m_act && !m_st && k >= m_g && k < m_g + RD_LAT;
        e_wen = m_act && m_st && k == m_g;
        e_if_rdy = m_act && !m_isd && k == m_rdy;
        e_d_rdy = m_act && m_isd && k == m_rdy;
        if (e_if_rdy) e_if_rdata = m_rd;
        if (e_d_rdy) e_d_rdata = m_rd;
        ctl = e_ren || e_wen;
        @(posedge clk); #1;
        check("ram_ren", ram_ren, e_ren);
        check("ram_wen", ram_wen, e_wen);
        check("ren_wen_overlap", ram_ren & ram_wen, 0);
        check("ram_addr", ram_addr, ctl ? m_addr : '0);
        check("ram_store", ram_store, e_wen ? m_wdata : '0);
        check("ram_width", ram_width, ctl ? m_w : '0);
        check("if_ready", if_ready, e_if_rdy);
        check("d_ready", d_ready, e_d_rdy);
        check("if_rdata", if_rdata, e_if_rdata);
        check("d_rdata", d_rdata, e_d_rdata);
        if (ram_wen) ram_mem[ram_addr] = ram_store;
        if (ram_ren) begin idx = ren_run; ren_run++; end
        else begin idx = -1; ren_run = 0; end
        ram_load = (idx == RD_LAT - 1) ? (ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : dflt(ram_addr))
                                       : 32'hDEAD_0BAD;
    endtask

    task automatic run_until_quiet(input int max_cycles);
        int c;
        for (c = 0; c < max_cycles && (if_req || d_req); c++) begin
            step();
            if (e_if_rdy) if_req = 1'b0;
            if (e_d_rdy) d_req = 1'b0;
        end
        check("quiet_timeout", if_req || d_req, 0);
        step();
    endtask

    initial begin
        logic [9:0] order;
        int n_gr, ren_cnt, rdy_at;
        word_t got;
        // reset held with both requests pending
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h300; d_addr = 32'h2000; d_width = LDST_WORD;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("t1_first_grant_d", ram_addr, 32'h2000);
        run_until_quiet(40);
        // fetch
        ref_mem[32'h100] = 32'h0050_0093; ram_mem[32'h100] = 32'h0050_0093;
        if_req = 1'b1; if_addr = 32'h100;
        step();
        check("t2_ren", ram_ren, 1);
        check("t2_addr", ram_addr, 32'h100);
        step();
        check("t2_ready", if_ready, 1);
        check("t2_rdata", if_rdata, 32'h0050_0093);
        if_req = 1'b0;
        step();
        // byte store
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_width = LDST_BYTE;
        step();
        check("t3_wen", ram_wen, 1);
        check("t3_store", ram_store, 32'hDEAD_BEEF);
        check("t3_width", ram_width, LDST_BYTE);
        step();
        check("t3_ready", d_ready, 1);
        check("t3_rdata", d_rdata, 0);
        d_req = 1'b0; d_wen = 1'b0;
        step();
        // continuous contention
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h400; d_addr = 32'h800; d_width = LDST_WORD;
        order = '0; n_gr = 0;
        for (int c = 0; c < 80 && n_gr < 10; c++) begin
            step();
            if (ram_ren) begin order = {order[8:0], ram_addr == 32'h800}; n_gr++; end
        end
        check("t4_grant_order", order, 10'b11110_11110);
        run_until_quiet(40);
        // reset during a load access
        d_req = 1'b1; d_addr = 32'h40;
        step();
        rst = 1'b1;
        step();
        check("t6_ren_cleared", ram_ren, 0);
        check("t6_no_ready", d_ready, 0);
        rst = 1'b0;
        run_until_quiet(20);
        check("t6_reissue_rdata", d_rdata, dflt(32'h40));
        // randomized traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = word_t'($urandom_range(0, 63) << 2);
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_wen = 1'($urandom_range(0, 1));
                d_addr = word_t'($urandom_range(0, 63) << 2); d_wdata = $urandom;
                d_width = LDST_WIDTH_W'($urandom_range(0, 2));
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
            if (e_if_rdy) if_req = 1'b0;
            if (e_d_rdy) d_req = 1'b0;
        end
        rst = 1'b0;
        run_until_quiet(40);
        // RD_LAT=3 load on the second instance
        rst3 = 1'b0; d_req3 = 1'b1; d_addr3 = 32'h40;
        ren_cnt = 0; rdy_at = 0; got = '0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (ram_ren3) begin
                ren_cnt++;
                ram_load3 = (ren_cnt == 3) ? 32'h1234_5678 : 32'hFFFF_FFFF;
            end else ram_load3 = 32'hFFFF_FFFF;
            if (d_ready3 && rdy_at == 0) begin rdy_at = c; d_req3 = 1'b0; got = d_rdata3; end
        end
        check("t5_ren_cycles", ren_cnt, 3);
        check("t5_latency", rdy_at, 4);
        check("t5_rdata", got, 32'h1234_5678);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
